// File: rtl/stack_sequencer.sv
// stack_sequencer: single-command-in-flight sequencer driving a push/pop/add/mul stack.
module stack_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [2:0]                           cmd_op,
  input  logic signed [DATA_WIDTH-1:0]         cmd_data,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic signed [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                           rsp_status,
  output logic [2:0]                           st_opcode,
  output logic [DATA_WIDTH-1:0]                st_data_in,
  input  logic [DATA_WIDTH-1:0]                st_data_out,
  input  logic                                 st_overflow,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     count
);
  localparam int CW = $clog2(STACK_DEPTH+1);
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic [1:0] rsp_status_q, rsp_status_d;
  logic [CW-1:0] count_q, count_d;
  logic reject;
  // Opcodes 0xx are no-op or reserved; 10x are the two-operand arithmetic ops.
  assign reject = !cmd_op[2]
               || (cmd_op == OP_PUSH && count_q == CW'(STACK_DEPTH))
               || (cmd_op == OP_POP && count_q == '0)
               || (!cmd_op[1] && count_q < CW'(2));
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    count_d      = count_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d         = cmd_op;
        data_d       = cmd_data;
        rsp_data_d   = '0;
        rsp_status_d = (cmd_op == OP_NOP) ? 2'b00 : 2'b10;
        state_d      = (cmd_op == OP_NOP || reject) ? RESP : ISSUE;
      end
      ISSUE: begin
        count_d = (op_q == OP_PUSH) ? count_q + 1'b1 : count_q - 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        rsp_data_d   = st_data_out;
        rsp_status_d = {1'b0, st_overflow && !op_q[1]};
        state_d      = RESP;
      end
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      data_q       <= '0;
      count_q      <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      count_q      <= count_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end
  assign cmd_ready  = state_q == IDLE;
  assign rsp_valid  = state_q == RESP;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign st_opcode  = (state_q == ISSUE) ? op_q : OP_NOP;
  assign st_data_in = data_q;
  assign count      = count_q;
endmodule
